// File: rtl/can_bit_timing.sv
// CAN bit-timing and sampling stage: synchronises the RX pin, divides clk into
// time quanta, and places one sample strobe per bit with hard sync and SJW-limited resync.
//
// state    | meaning
// ST_SYNC  | sync segment, 1 tq; tx_point marks its first cycle
// ST_TSEG1 | prop + phase1; its final tick is the sample point (lengthened by ext)
// ST_TSEG2 | phase2; shortened by shr, or cut off by an early-edge restart
module can_bit_timing #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] brp,
  input  logic [3:0]         tseg1,
  input  logic [2:0]         tseg2,
  input  logic [1:0]         sjw,
  input  logic               hard_sync_en,
  input  logic               rx_in,
  output logic               bit_out,
  output logic               can_clk_en,
  output logic               tx_point
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               rx_meta, rx_sync, rx_prev;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [4:0]         tq_cnt, tq_cnt_nxt;
  logic [2:0]         ext, ext_nxt;
  logic [2:0]         shr, shr_nxt;
  logic               resync_done, resync_done_nxt;
  logic               bit_nxt, can_clk_en_nxt, tx_point_nxt;

  logic               edge_fall, tq_tick, hard_sync, resync, restart;
  logic [2:0]         sjw_tq;
  logic [4:0]         k_plus1, n_remain;

  assign edge_fall = rx_prev & ~rx_sync;
  assign tq_tick   = (presc == brp);
  assign sjw_tq    = {1'b0, sjw} + 3'd1;
  assign hard_sync = edge_fall & hard_sync_en;
  assign resync    = edge_fall & ~hard_sync_en & ~resync_done & bit_out;
  assign k_plus1   = tq_cnt + 5'd1;
  // Quanta left in phase2 including the current one.
  assign n_remain  = {2'b00, tseg2} + 5'd1 - tq_cnt;

  always_comb begin
    state_nxt       = state;
    presc_nxt       = tq_tick ? '0 : presc + PRESC_W'(1);
    tq_cnt_nxt      = tq_cnt;
    ext_nxt         = ext;
    shr_nxt         = shr;
    resync_done_nxt = resync_done;
    bit_nxt         = bit_out;
    can_clk_en_nxt  = 1'b0;
    tx_point_nxt    = 1'b0;
    restart         = 1'b0;

    if (hard_sync) begin
      restart         = 1'b1;
      resync_done_nxt = 1'b0;
    end else if (resync) begin
      resync_done_nxt = 1'b1;
      case (state)
        ST_TSEG1: ext_nxt = (k_plus1 < {2'b00, sjw_tq}) ? k_plus1[2:0] : sjw_tq;
        ST_TSEG2: begin
          if (n_remain <= {2'b00, sjw_tq}) begin
            restart      = 1'b1;
            tx_point_nxt = 1'b1;
          end else begin
            shr_nxt = sjw_tq;
          end
        end
        default: ;
      endcase
    end

    // The freshly computed ext/shr take effect on a tick in the same cycle.
    if (restart) begin
      presc_nxt  = '0;
      state_nxt  = ST_TSEG1;
      tq_cnt_nxt = '0;
      ext_nxt    = '0;
      shr_nxt    = '0;
    end else if (tq_tick) begin
      case (state)
        ST_SYNC: begin
          state_nxt  = ST_TSEG1;
          tq_cnt_nxt = '0;
        end
        ST_TSEG1: begin
          if (tq_cnt == {1'b0, tseg1} + {2'b00, ext_nxt}) begin
            state_nxt       = ST_TSEG2;
            tq_cnt_nxt      = '0;
            bit_nxt         = rx_sync;
            can_clk_en_nxt  = 1'b1;
            ext_nxt         = '0;
            shr_nxt         = '0;
            resync_done_nxt = 1'b0;
          end else begin
            tq_cnt_nxt = k_plus1;
          end
        end
        ST_TSEG2: begin
          if (tq_cnt + {2'b00, shr_nxt} == {2'b00, tseg2}) begin
            state_nxt    = ST_SYNC;
            tq_cnt_nxt   = '0;
            tx_point_nxt = 1'b1;
          end else begin
            tq_cnt_nxt = k_plus1;
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= ST_SYNC;
      presc       <= '0;
      tq_cnt      <= '0;
      ext         <= '0;
      shr         <= '0;
      resync_done <= 1'b0;
      bit_out     <= 1'b1;
      can_clk_en  <= 1'b0;
      tx_point    <= 1'b0;
    end else if (!enable) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= ST_SYNC;
      presc       <= '0;
      tq_cnt      <= '0;
      ext         <= '0;
      shr         <= '0;
      resync_done <= 1'b0;
      bit_out     <= 1'b1;
      can_clk_en  <= 1'b0;
      tx_point    <= 1'b0;
    end else begin
      rx_meta     <= rx_in;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      state       <= state_nxt;
      presc       <= presc_nxt;
      tq_cnt      <= tq_cnt_nxt;
      ext         <= ext_nxt;
      shr         <= shr_nxt;
      resync_done <= resync_done_nxt;
      bit_out     <= bit_nxt;
      can_clk_en  <= can_clk_en_nxt;
      tx_point    <= tx_point_nxt;
    end
  end

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: a clock-position model of the bit timeline is compared
// against the DUT every cycle; directed scenarios pin the model with literal timings.
module tb_can_bit_timing;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] brp = 8'd9;
  logic [3:0]    tseg1 = 4'd5;
  logic [2:0]    tseg2 = 3'd2;
  logic [1:0]    sjw = 2'd0;
  logic          hard_sync_en = 1'b0;
  logic          rx_in = 1'b1;
  logic          bit_out, can_clk_en, tx_point;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  can_bit_timing #(.PRESC_W(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .brp(brp), .tseg1(tseg1),
    .tseg2(tseg2), .sjw(sjw), .hard_sync_en(hard_sync_en), .rx_in(rx_in),
    .bit_out(bit_out), .can_clk_en(can_clk_en), .tx_point(tx_point)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: position in clocks since the start of the current bit, plus the
  // lengthening (ext) and shortening (shr) of the bit in quanta.
  bit m_s1 = 1'b1, m_sync = 1'b1, m_prev = 1'b1;
  bit m_bit = 1'b1, m_cce = 1'b0, m_txp = 1'b0, m_flag = 1'b0, m_sampled = 1'b0;
  int m_pos = 0, m_ext = 0, m_shr = 0, m_spos = 0;

  task automatic model_clear();
    m_s1 = 1'b1; m_sync = 1'b1; m_prev = 1'b1;
    m_bit = 1'b1; m_cce = 1'b0; m_txp = 1'b0; m_flag = 1'b0; m_sampled = 1'b0;
    m_pos = 0; m_ext = 0; m_shr = 0; m_spos = 0;
  endtask

  task automatic model_step();
    int t, l1, l2, sj, k;
    bit edge_seen, restart, nb, ncce, ntxp;
    t  = int'(brp) + 1;
    l1 = int'(tseg1) + 1;
    l2 = int'(tseg2) + 1;
    sj = int'(sjw) + 1;
    edge_seen = m_prev && !m_sync;
    restart = 1'b0; nb = m_bit; ncce = 1'b0; ntxp = 1'b0;
    if (edge_seen && hard_sync_en) begin
      restart = 1'b1;
      m_flag = 1'b0;
    end else if (edge_seen && !m_flag && m_bit) begin
      m_flag = 1'b1;
      if (m_pos >= t) begin
        if (!m_sampled) begin
          k = (m_pos - t) / t;
          m_ext = (k + 1 < sj) ? k + 1 : sj;
        end else begin
          k = (m_pos - m_spos) / t;
          if (l2 - k <= sj) begin
            restart = 1'b1;
            ntxp = 1'b1;
          end else begin
            m_shr = sj;
          end
        end
      end
    end
    if (restart) begin
      m_pos = t; m_ext = 0; m_shr = 0; m_sampled = 1'b0;
    end else if (!m_sampled && m_pos == (1 + l1 + m_ext) * t - 1) begin
      nb = m_sync; ncce = 1'b1; m_ext = 0; m_shr = 0; m_flag = 1'b0;
      m_sampled = 1'b1; m_spos = m_pos + 1; m_pos = m_pos + 1;
    end else if (m_sampled && m_pos == m_spos + (l2 - m_shr) * t - 1) begin
      m_pos = 0; m_sampled = 1'b0; ntxp = 1'b1;
    end else begin
      m_pos = m_pos + 1;
    end
    m_bit = nb; m_cce = ncce; m_txp = ntxp;
    m_prev = m_sync; m_sync = m_s1; m_s1 = rx_in;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || !enable) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("bit_out", bit_out, m_bit);
      chk("can_clk_en", can_clk_en, m_cce);
      chk("tx_point", tx_point, m_txp);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cce(output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_cce) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_cce: no strobe within 400 cycles, required one (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_txp(output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_txp) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_txp: no tx_point within 400 cycles, required one (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, t0, t1, d, hold;
    #1 reset = 1'b0;
    #1;
    chk("rst_bit_out", bit_out, 1);
    chk("rst_can_clk_en", can_clk_en, 0);
    chk("rst_tx_point", tx_point, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    chk_en = 1'b1;

    // Idle recessive bus
    wait_cce(c0); wait_cce(c1);
    chk("idle_period", c1 - c0, 100);
    chk("idle_bit", m_bit, 1);
    wait_txp(t0);
    chk("cce_to_txp", t0 - c1, 30);
    wait_cce(c2);
    chk("txp_to_cce", c2 - t0, 70);

    // Hard synchronisation
    wait_txp(t0); idle(31);
    hard_sync_en = 1'b1; rx_in = 1'b0; d = cyc;
    wait_cce(c0);
    chk("hs_first_cce", c0 - d, 63);
    chk("hs_bit", m_bit, 0);
    wait_cce(c1);
    chk("hs_period", c1 - c0, 100);
    rx_in = 1'b1;
    wait_cce(c0); wait_cce(c0);
    chk("hs_recover_bit", m_bit, 1);
    hard_sync_en = 1'b0;

    // Late edge at TSEG1 tq_cnt=3, SJW-clamped lengthening
    wait_cce(c0); wait_txp(t0); idle(43); rx_in = 1'b0;
    wait_cce(c1);
    chk("late_period", c1 - c0, 110);
    idle(10); rx_in = 1'b1;
    wait_cce(c2);
    chk("late_next_period", c2 - c1, 100);

    // Second edge within the same bit is ignored
    wait_cce(c0); wait_txp(t0); idle(43); rx_in = 1'b0;
    idle(7); rx_in = 1'b1; idle(8); rx_in = 1'b0;
    wait_cce(c1);
    chk("second_edge_period", c1 - c0, 110);
    rx_in = 1'b1;
    wait_cce(c0);
    chk("second_edge_recover_bit", m_bit, 1);

    // Early edge at TSEG2 tq_cnt=2: restart with tx_point
    idle(23); rx_in = 1'b0; d = cyc;
    wait_txp(t1);
    chk("early_restart_txp", t1 - d, 3);
    wait_cce(c1);
    chk("early_restart_cce", c1 - d, 63);
    rx_in = 1'b1;
    wait_cce(c0); wait_cce(c0);
    chk("early_recover_bit", m_bit, 1);

    // Early edge at TSEG2 tq_cnt=0: shortened bit
    idle(3); rx_in = 1'b0;
    wait_cce(c1);
    chk("short_period", c1 - c0, 90);
    chk("short_bit", m_bit, 0);

    // Edge while the previous bit was dominant: no resync
    idle(15); rx_in = 1'b1;
    wait_txp(t0); idle(43); rx_in = 1'b0;
    wait_cce(c2);
    chk("dominant_no_resync", c2 - c1, 100);

    // Asynchronous reset in mid TSEG1 with rx_in low
    wait_txp(t0); idle(30);
    reset = 1'b0;
    #1;
    chk("mid_rst_bit_out", bit_out, 1);
    chk("mid_rst_can_clk_en", can_clk_en, 0);
    chk("mid_rst_tx_point", tx_point, 0);
    idle(5);
    reset = 1'b1;
    wait_cce(c0);
    chk("post_rst_bit", m_bit, 0);
    rx_in = 1'b1;
    wait_cce(c0);

    // Randomised configurations and stimulus
    for (int s = 0; s < 6; s++) begin
      enable = 1'b0;
      idle(3);
      brp   = PW'($urandom_range(0, 4));
      tseg1 = 4'($urandom_range(0, 15));
      tseg2 = 3'($urandom_range(0, 7));
      sjw   = 2'($urandom_range(0, (tseg2 < 3'd3) ? int'(tseg2) : 3));
      idle(1);
      enable = 1'b1;
      for (int j = 0; j < 150; j++) begin
        hold = int'($urandom_range(1, 25 * (int'(brp) + 1)));
        if ($urandom_range(0, 3) == 0) hard_sync_en = ~hard_sync_en;
        if ($urandom_range(0, 3) != 0) rx_in = ~rx_in;
        if ($urandom_range(0, 50) == 0) begin
          enable = 1'b0;
          idle(2);
          enable = 1'b1;
        end
        idle(hold);
      end
    end

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
